// File: rtl/cups_pkg.sv
// Shared types and default sizing for the three-cup pour puzzle blocks.
package cups_pkg;

  typedef enum logic [1:0] {
    LARGE  = 2'd0,
    MEDIUM = 2'd1,
    SMALL  = 2'd2
  } cup_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECIDE,
    S_ISSUE,
    S_DONE,
    S_FAIL
  } drv_state_t;

  localparam int DEF_CAP_L     = 12;
  localparam int DEF_CAP_M     = 8;
  localparam int DEF_CAP_S     = 5;
  localparam int DEF_TARGET    = 6;
  localparam int DEF_MAX_MOVES = 15;
  localparam int DEF_VW        = 4;

endpackage

// File: rtl/cups_pour_step.sv
// Combinational pour: moves min(src, room in dst) from one cup to another.
// Shared by the driver's shadow state and by plant models.
module cups_pour_step
  import cups_pkg::*;
#(
  parameter int VW = DEF_VW
) (
  input  logic [VW-1:0] vol_l,
  input  logic [VW-1:0] vol_m,
  input  logic [VW-1:0] vol_s,
  input  logic [VW-1:0] cap_l,
  input  logic [VW-1:0] cap_m,
  input  logic [VW-1:0] cap_s,
  input  cup_t          from,
  input  cup_t          to,
  output logic [VW-1:0] next_l,
  output logic [VW-1:0] next_m,
  output logic [VW-1:0] next_s
);

  logic [VW-1:0] src;
  logic [VW-1:0] dst;
  logic [VW-1:0] cap_dst;
  logic [VW-1:0] room;
  logic [VW-1:0] amt;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    src     = '0;
    dst     = '0;
    cap_dst = '0;
    case (from)
      LARGE:   src = vol_l;
      MEDIUM:  src = vol_m;
      SMALL:   src = vol_s;
      default: src = '0;
    endcase
    case (to)
      LARGE:   begin dst = vol_l; cap_dst = cap_l; end
      MEDIUM:  begin dst = vol_m; cap_dst = cap_m; end
      SMALL:   begin dst = vol_s; cap_dst = cap_s; end
      default: begin dst = '0;    cap_dst = '0;    end
    endcase
    room = cap_dst - dst;
    amt  = (src < room) ? src : room;

    // Subtract then add keeps a degenerate from==to pour a no-op.
    next_l = vol_l - ((from == LARGE)  ? amt : '0) + ((to == LARGE)  ? amt : '0);
    next_m = vol_m - ((from == MEDIUM) ? amt : '0) + ((to == MEDIUM) ? amt : '0);
    next_s = vol_s - ((from == SMALL)  ? amt : '0) + ((to == SMALL)  ? amt : '0);
  end

endmodule

// File: rtl/cups_pour_driver.sv
// Greedy move generator for the three-cup pour puzzle with a valid/ack move stream.
// Optional plant cross-check enabled by defining CUPS_POUR_DRIVER_CHECK_EN.
module cups_pour_driver
  import cups_pkg::*;
#(
  parameter int CAP_L     = DEF_CAP_L,
  parameter int CAP_M     = DEF_CAP_M,
  parameter int CAP_S     = DEF_CAP_S,
  parameter int TARGET    = DEF_TARGET,
  parameter int MAX_MOVES = DEF_MAX_MOVES,
  parameter int VW        = DEF_VW
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  output logic [1:0]    from,
  output logic [1:0]    to,
  output logic          move_valid,
  input  logic          move_ack,
  output logic          done,
  output logic          fail,
  output logic [3:0]    move_count,
  output logic [VW-1:0] vol_l,
  output logic [VW-1:0] vol_m,
  output logic [VW-1:0] vol_s
`ifdef CUPS_POUR_DRIVER_CHECK_EN
  ,
  input  logic [VW-1:0] plant_l,
  input  logic [VW-1:0] plant_m,
  input  logic [VW-1:0] plant_s,
  output logic          mismatch
`endif
);

  localparam logic [VW-1:0] CL   = VW'(CAP_L);
  localparam logic [VW-1:0] CM   = VW'(CAP_M);
  localparam logic [VW-1:0] CS   = VW'(CAP_S);
  localparam logic [VW-1:0] TGT  = VW'(TARGET);
  localparam logic [3:0]    MAXM = 4'(MAX_MOVES);

  drv_state_t    state;
  cup_t          from_q;
  cup_t          to_q;
  cup_t          rule_from;
  cup_t          rule_to;
  logic [VW-1:0] step_l;
  logic [VW-1:0] step_m;
  logic [VW-1:0] step_s;
  logic          plant_diff;

  assign from = from_q;
  assign to   = to_q;

`ifdef CUPS_POUR_DRIVER_CHECK_EN
  assign plant_diff = (plant_l != vol_l) || (plant_m != vol_m) || (plant_s != vol_s);
`else
  assign plant_diff = 1'b0;
`endif

  // Greedy rule: empty a full small cup first, refill an empty medium, else top up small.
  always_comb begin
    rule_from = MEDIUM;
    rule_to   = SMALL;
    if (vol_s == CS) begin
      rule_from = SMALL;
      rule_to   = LARGE;
    end else if (vol_m == '0) begin
      rule_from = LARGE;
      rule_to   = MEDIUM;
    end
  end

  cups_pour_step #(.VW(VW)) u_step (
    .vol_l  (vol_l),
    .vol_m  (vol_m),
    .vol_s  (vol_s),
    .cap_l  (CL),
    .cap_m  (CM),
    .cap_s  (CS),
    .from   (from_q),
    .to     (to_q),
    .next_l (step_l),
    .next_m (step_m),
    .next_s (step_s)
  );

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      vol_l      <= CL;
      vol_m      <= '0;
      vol_s      <= '0;
      from_q     <= LARGE;
      to_q       <= MEDIUM;
      move_valid <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      move_count <= '0;
`ifdef CUPS_POUR_DRIVER_CHECK_EN
      mismatch   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            vol_l      <= CL;
            vol_m      <= '0;
            vol_s      <= '0;
            move_count <= '0;
            done       <= 1'b0;
            fail       <= 1'b0;
`ifdef CUPS_POUR_DRIVER_CHECK_EN
            mismatch   <= 1'b0;
`endif
            state      <= S_DECIDE;
          end
        end

        S_DECIDE: begin
          if (plant_diff) begin
`ifdef CUPS_POUR_DRIVER_CHECK_EN
            mismatch <= 1'b1;
`endif
            fail     <= 1'b1;
            state    <= S_FAIL;
          end else if (vol_l == TGT && vol_m == TGT) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (move_count == MAXM) begin
            fail  <= 1'b1;
            state <= S_FAIL;
          end else begin
            from_q     <= rule_from;
            to_q       <= rule_to;
            move_valid <= 1'b1;
            state      <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (move_ack) begin
            vol_l      <= step_l;
            vol_m      <= step_m;
            vol_s      <= step_s;
            move_count <= move_count + 4'd1;
            move_valid <= 1'b0;
            state      <= S_DECIDE;
          end
        end

        default: begin
          move_valid <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cups_pour_driver.sv
// Directed bench for cups_pour_driver: literal move/volume tables plus a transaction-level greedy model.
module tb_cups_pour_driver;
  import cups_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       move_ack = 1'b0;
  logic [1:0] from, to;
  logic       move_valid, done, fail;
  logic [3:0] move_count, vol_l, vol_m, vol_s;

  logic       start5 = 1'b0;
  logic       move_ack5 = 1'b0;
  logic [1:0] from5, to5;
  logic       move_valid5, done5, fail5;
  logic [3:0] move_count5, vol_l5, vol_m5, vol_s5;

  always #5 clock = ~clock;

  cups_pour_driver dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .from(from), .to(to), .move_valid(move_valid), .move_ack(move_ack),
    .done(done), .fail(fail), .move_count(move_count),
    .vol_l(vol_l), .vol_m(vol_m), .vol_s(vol_s)
  );

  cups_pour_driver #(.MAX_MOVES(5)) dut5 (
    .clock(clock), .reset_n(reset_n), .start(start5),
    .from(from5), .to(to5), .move_valid(move_valid5), .move_ack(move_ack5),
    .done(done5), .fail(fail5), .move_count(move_count5),
    .vol_l(vol_l5), .vol_m(vol_m5), .vol_s(vol_s5)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Hand-derived solution for the default capacities (12,8,5) and target 6.
  int exp_f [7] = '{0, 1, 2, 1, 0, 1, 2};
  int exp_t [7] = '{1, 2, 0, 2, 1, 2, 0};
  int exp_v [7][3] = '{'{4,8,0}, '{4,3,5}, '{9,3,0}, '{9,0,3}, '{1,8,3}, '{1,6,5}, '{6,6,0}};

  // Transaction-level model: cup volumes advanced once per accepted move.
  int cap [3] = '{12, 8, 5};
  int m_v [3];
  int m_count;
  bit model_on = 1'b0;
  int sb_f, sb_t;

  function automatic void model_init();
    m_v = '{12, 0, 0};
    m_count = 0;
  endfunction

  function automatic void model_move(output int f, output int t);
    if (m_v[2] == cap[2])  begin f = 2; t = 0; end
    else if (m_v[1] == 0)  begin f = 0; t = 1; end
    else                   begin f = 1; t = 2; end
  endfunction

  function automatic void model_pour();
    int f, t, amt;
    model_move(f, t);
    amt = (m_v[f] < cap[t] - m_v[t]) ? m_v[f] : cap[t] - m_v[t];
    m_v[f] -= amt;
    m_v[t] += amt;
    m_count++;
  endfunction

  always @(posedge clock)
    if (model_on && reset_n && move_valid && move_ack) model_pour();

  always @(negedge clock)
    if (model_on && reset_n && move_valid) begin
      model_move(sb_f, sb_t);
      check("sb_from", from, sb_f);
      check("sb_to", to, sb_t);
      check("sb_vol_l", vol_l, m_v[0]);
      check("sb_vol_m", vol_m, m_v[1]);
      check("sb_vol_s", vol_s, m_v[2]);
      check("sb_count", move_count, m_count);
    end

  task automatic start_solve();
    model_init();
    model_on = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("start_decide_valid", move_valid, 0);
    check("start_done_clr", done, 0);
    check("start_fail_clr", fail, 0);
    check("start_count_clr", move_count, 0);
    check("start_vol_l", vol_l, 12);
    @(negedge clock);
    check("first_valid_latency", move_valid, 1);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!move_valid && n < 8) begin
      @(negedge clock);
      n++;
    end
    check("valid_timeout", move_valid, 1);
  endtask

  task automatic run_moves(input int first, input int last, input int delay_move, input int delay_cyc);
    for (int i = first; i < last; i++) begin
      wait_valid();
      check("move_from", from, exp_f[i]);
      check("move_to", to, exp_t[i]);
      if (i == delay_move) begin
        move_ack = 1'b0;
        for (int k = 0; k < delay_cyc; k++) begin
          @(negedge clock);
          check("hold_valid", move_valid, 1);
          check("hold_from", from, exp_f[i]);
          check("hold_to", to, exp_t[i]);
          check("hold_vol_l", vol_l, exp_v[i-1][0]);
          check("hold_vol_m", vol_m, exp_v[i-1][1]);
          check("hold_vol_s", vol_s, exp_v[i-1][2]);
          check("hold_count", move_count, i);
        end
      end
      move_ack = 1'b1;
      @(negedge clock);
      check("gap_valid", move_valid, 0);
      check("after_vol_l", vol_l, exp_v[i][0]);
      check("after_vol_m", vol_m, exp_v[i][1]);
      check("after_vol_s", vol_s, exp_v[i][2]);
      check("after_count", move_count, i + 1);
      if (i < 6) begin
        @(negedge clock);
        check("gap_one_cycle", move_valid, 1);
      end
    end
  endtask

  task automatic check_solved();
    check("decide_done_low", done, 0);
    @(negedge clock);
    check("final_done", done, 1);
    check("final_fail", fail, 0);
    check("final_count", move_count, 7);
    check("final_valid", move_valid, 0);
    check("final_vol_l", vol_l, 6);
    check("final_vol_m", vol_m, 6);
    check("final_vol_s", vol_s, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    #12;
    check("rst_valid", move_valid, 0);
    check("rst_done", done, 0);
    check("rst_fail", fail, 0);
    check("rst_count", move_count, 0);
    check("rst_vol_l", vol_l, 12);
    check("rst_vol_m", vol_m, 0);
    check("rst_vol_s", vol_s, 0);
    check("rst_from", from, 0);
    check("rst_to", to, 1);
    @(negedge clock);
    reset_n = 1'b1;

    // Ack while idle is ignored
    move_ack = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_ack_valid", move_valid, 0);
    check("idle_ack_count", move_count, 0);
    check("idle_ack_vol_l", vol_l, 12);
    check("idle_ack_done", done, 0);

    // Full solve with ack held high
    start_solve();
    run_moves(0, 7, -1, 0);
    check_solved();

    // Restart from DONE with a 3-cycle ack stall on move 2
    start_solve();
    run_moves(0, 7, 1, 3);
    check_solved();

    // Async reset during the 4th move's issue cycle
    move_ack = 1'b0;
    start_solve();
    run_moves(0, 3, -1, 0);
    move_ack = 1'b0;
    check("pre_rst_valid", move_valid, 1);
    #2;
    reset_n = 1'b0;
    model_init();
    #1;
    check("async_rst_valid", move_valid, 0);
    check("async_rst_vol_l", vol_l, 12);
    check("async_rst_vol_m", vol_m, 0);
    check("async_rst_vol_s", vol_s, 0);
    check("async_rst_count", move_count, 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    start_solve();
    run_moves(0, 7, -1, 0);
    check_solved();

    // Start pulsed while a move is pending is ignored
    move_ack = 1'b0;
    start_solve();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("issue_start_valid", move_valid, 1);
    check("issue_start_from", from, 0);
    check("issue_start_to", to, 1);
    check("issue_start_count", move_count, 0);
    @(negedge clock);
    check("issue_start_valid2", move_valid, 1);
    check("issue_start_vol_l", vol_l, 12);
    run_moves(0, 7, -1, 0);
    check_solved();
    model_on = 1'b0;

    // Move budget of 5 runs out before the target is reached
    move_ack5 = 1'b1;
    start5 = 1'b1;
    @(negedge clock);
    start5 = 1'b0;
    begin
      int n = 0;
      while (!fail5 && n < 60) begin
        @(negedge clock);
        n++;
      end
    end
    check("budget_fail", fail5, 1);
    check("budget_done", done5, 0);
    check("budget_count", move_count5, 5);
    check("budget_valid", move_valid5, 0);
    check("budget_vol_l", vol_l5, 1);
    check("budget_vol_m", vol_m5, 8);
    check("budget_vol_s", vol_s5, 3);
    repeat (3) @(negedge clock);
    check("budget_fail_sticky", fail5, 1);
    check("budget_no_more_moves", move_valid5, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
